// File: rtl/div_if.sv
// Handshake/operand bundle between the execute-stage pipeline and div_unit.
//   start/sign/dividend/divisor/lz_count/cancel : pipeline -> divider
//   busy/ready/quotient/remainder                : divider -> pipeline
// master = pipeline side, slave = divider side.
interface div_if;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  lz_count;
  logic        cancel;
  logic        busy;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output start, sign, dividend, divisor, lz_count, cancel,
    input  busy, ready, quotient, remainder
  );

  modport slave (
    input  start, sign, dividend, divisor, lz_count, cancel,
    output busy, ready, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned restoring divider (DIV/DIVU).
// Quotient goes to LO, remainder to HI. The dividend magnitude is pre-shifted
// past its leading zeros (lz_count from clo_clz), so only 32-lz_count
// iterations run.
// Ports:
//   clk  : clock, rising edge
//   clrn : synchronous reset, active-low
//   bus  : div_if.slave -- start/sign/dividend/divisor/lz_count/cancel in,
//          busy/ready/quotient/remainder out
module div_unit (
  input  logic  clk,
  input  logic  clrn,
  div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] dvd;        // pre-shifted dividend magnitude, consumed MSB first
  logic [31:0] dsr;        // divisor magnitude
  logic [31:0] rem;        // partial remainder
  logic [31:0] q;          // quotient magnitude
  logic [5:0]  cnt;
  logic        qneg, rneg;
  logic [31:0] q_hold, r_hold;

  logic        accept, early;
  logic [31:0] a_mag, b_mag;
  logic [32:0] t;
  logic        ge;
  logic [31:0] q_fix, r_fix;

  assign a_mag  = (bus.sign && bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign b_mag  = (bus.sign && bus.divisor[31])  ? -bus.divisor  : bus.divisor;
  assign accept = (state == IDLE) && bus.start && !bus.cancel;
  // Divide-by-zero and zero dividend skip the iteration loop entirely.
  assign early  = (bus.divisor == '0) || (bus.lz_count == 6'd32);

  assign t  = {rem, dvd[31]};
  assign ge = (t >= {1'b0, dsr});

  assign q_fix = qneg ? -q : q;
  assign r_fix = rneg ? -rem : rem;

  // State register
  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = early ? DONE : RUN;
      RUN: begin
        if (bus.cancel)     state_nxt = IDLE;
        else if (cnt == 6'd1) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: during an uncancelled DONE the fixed-up result is presented
  // directly so it is valid in the ready cycle; otherwise the held copy shows.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.ready     = (state == DONE) && !bus.cancel;
    bus.quotient  = bus.ready ? q_fix : q_hold;
    bus.remainder = bus.ready ? r_fix : r_hold;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!clrn) begin
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      q_hold <= '0;
      r_hold <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dsr  <= b_mag;
            qneg <= bus.sign & (bus.dividend[31] ^ bus.divisor[31]);
            rneg <= bus.sign & bus.dividend[31];
            if (bus.divisor == '0) begin
              // Raw dividend returned as remainder; sign flags cleared so
              // the shared fix-up path leaves both values untouched.
              q    <= '1;
              rem  <= bus.dividend;
              qneg <= 1'b0;
              rneg <= 1'b0;
              cnt  <= '0;
            end else if (bus.lz_count == 6'd32) begin
              q   <= '0;
              rem <= '0;
              cnt <= '0;
            end else begin
              dvd <= a_mag << bus.lz_count;
              rem <= '0;
              q   <= '0;
              cnt <= 6'd32 - bus.lz_count;
            end
          end
        end
        RUN: begin
          if (!bus.cancel) begin
            dvd <= {dvd[30:0], 1'b0};
            cnt <= cnt - 6'd1;
            // rem < dsr always holds, so the low 32 bits of t - dsr are exact.
            rem <= ge ? (t[31:0] - dsr) : t[31:0];
            q   <= {q[30:0], ge};
          end
        end
        DONE: begin
          if (!bus.cancel) begin
            q_hold <= q_fix;
            r_hold <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results computed
// with plain arithmetic; a monitor pops and compares on every ready pulse.
module tb_div_unit;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  div_if bus ();

  div_unit dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: leading-zero count of the magnitude and the architectural result.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output int lz);
    logic [31:0] ma;
    int sx, sy;
    ma = (sgn && a[31]) ? -a : a;
    lz = 32;
    for (int i = 0; i < 32; i++) if (ma[i]) lz = 31 - i;
    if (b == 0) begin
      q = 32'hFFFFFFFF; r = a;
    end else if (a == 0) begin
      q = 0; r = 0;
    end else if (sgn) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000; r = 0;
      end else begin
        sx = a; sy = b;
        q = sx / sy; r = sx % sy;
      end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (clrn === 1'b1 && bus.ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_ready: got ready=1, expected ready=0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("ready_cycle", cyc, e.cyc);
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.busy !== 1'b0 && k < 60) begin
      @(negedge clk); k++;
    end
    if (k >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy=%b, expected busy=0", bus.busy);
    end
  endtask

  // Drives start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    logic [31:0] q, r;
    int lz;
    exp_t x;
    wait_idle();
    model(sgn, a, b, q, r, lz);
    bus.start    = 1'b1;
    bus.sign     = sgn;
    bus.dividend = a;
    bus.divisor  = b;
    bus.lz_count = 6'(lz);
    if (push) begin
      x.q   = q;
      x.r   = r;
      x.cyc = cyc + ((b == 0 || lz == 32) ? 1 : 33 - lz);
      sbq.push_back(x);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 60) begin
      @(negedge clk); k++;
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL result_timeout: got no ready, expected %0d result(s)", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb;

    clrn = 1'b0;
    bus.start = 1'b0; bus.sign = 1'b0; bus.cancel = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.lz_count = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_ready", 32'(bus.ready), 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    clrn = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    check("busy_in_run", 32'(bus.busy), 1);
    drain();
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 0);

    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);        drain();
    issue(1'b0, 32'h12345678, 32'd0, 1'b1);        drain();
    issue(1'b0, 32'd0, 32'd5, 1'b1);               drain();

    // Long divide with a start in cycle 5 that must be ignored
    issue(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd3; bus.lz_count = 6'd25;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain();

    // Cancel in cycle 3
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    repeat (2) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 32'(bus.busy), 0);
    check("cancel_ready", 32'(bus.ready), 0);
    check("cancel_hold_q", bus.quotient, last_q);
    check("cancel_hold_r", bus.remainder, last_r);
    repeat (40) @(negedge clk);
    check("idle_hold_q", bus.quotient, last_q);

    // Reset in cycle 10 of a run
    issue(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    repeat (9) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(bus.busy), 0);
    check("midreset_ready", 32'(bus.ready), 0);
    check("midreset_quotient", bus.quotient, 0);
    check("midreset_remainder", bus.remainder, 0);
    clrn = 1'b1;
    last_q = '0; last_r = '0;
    repeat (40) @(negedge clk);

    // Randomized operands over a spread of magnitudes
    for (int i = 0; i < 60; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 19) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      issue(rs, ra, rb, 1'b1);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed/unsigned divider for the execute stage; implements DIV/DIVU, quotient to LO, remainder to HI. It sits directly downstream of clo_clz. clo_clz (CLZ mode, one_or_zero=0) is driven with the dividend magnitude, and its result[5:0] feeds lz_count here. The divider pre-shifts past leading zeros, so it runs only 32-lz_count iterations instead of a fixed 32. Start/busy/ready handshake with the pipeline; cancel input for flushes.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  clock; all state changes on rising edge
- clrn  in  1  synchronous reset, active-low
- start  in  1  request; sampled only in IDLE
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- dividend  in  32  sampled with start
- divisor  in  32  sampled with start
- lz_count  in  6  leading-zero count of the dividend magnitude, 0..32, valid with start; must be exact, not checked
- cancel  in  1  abort current operation (pipeline flush)
- busy  out  1  high in RUN and DONE
- ready  out  1  one-cycle pulse in DONE; results valid from this cycle
- quotient  out  32  registered LO result
- remainder  out  32  registered HI result

## Operation
- Magnitudes: if sign=1 and operand bit31=1, take the two's complement, else pass through. Latch qneg = sign & (dividend[31]^divisor[31]) and rneg = sign & dividend[31].
- States:
  - IDLE -> RUN on start & !cancel.
  - IDLE -> DONE directly on start & !cancel when divisor==0 or lz_count==32.
  - RUN -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE unconditionally.
  - RUN/DONE -> IDLE on cancel.
- Load (IDLE, start accepted): dvd = |dividend| << lz_count; rem = 33'b0; q = 0; cnt = 32 - lz_count.
- RUN iteration (restoring): t = {rem[31:0], dvd[31]}; dvd <<= 1. If t >= {1'b0,|divisor|}, rem = t - |divisor| and shift 1 into q; else rem = t and shift 0 into q. cnt decrements.
- DONE writes quotient/remainder:
  - Normal: quotient = qneg ? -q : q; remainder = rneg ? -rem[31:0] : rem[31:0].
  - divisor==0: quotient = 32'hFFFFFFFF, remainder = dividend as sampled, no sign fix.
  - Dividend 0 (lz_count==32, divisor!=0): quotient = 0, remainder = 0.
  - Signed 32'h80000000 / 32'hFFFFFFFF: quotient = 32'h80000000, remainder = 0 (natural wrap, no trap).
- quotient/remainder are written only in DONE and hold otherwise, including across cancel and while idle.
- start while busy is ignored, including in the DONE cycle. It is not queued.
- cancel has priority over start in the same cycle. With cancel high in DONE, ready is not asserted and the outputs are not updated.

## Timing
- Reset, clrn low at an edge: state = IDLE, busy = 0, ready = 0, quotient = 0, remainder = 0, cnt = 0. Reset in any state aborts the operation; no ready follows.
- Start accepted in cycle 0, n = 32 - lz_count:
  - RUN occupies cycles 1..n.
  - DONE and ready are in cycle n+1.
  - busy is high in cycles 1..n+1.
- Latency: 2 cycles (n=1) to 33 cycles (n=32). Divide-by-zero and zero dividend: DONE in cycle 1.
- Earliest next accepted start is cycle n+2.
- cancel sampled high in cycle k while busy: state is IDLE in cycle k+1, busy = 0, ready never pulses.

## Test plan
- Unsigned 100/7, lz_count=25, start at cycle 0 -> busy in cycles 1..8, ready in cycle 8, quotient=14, remainder=2.
- Signed 32'hFFFFFFF9 / 2 (-7/2), lz_count=29 -> ready in cycle 4, quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF.
- Divisor 0, dividend 32'h12345678 -> ready in cycle 1, quotient=32'hFFFFFFFF, remainder=32'h12345678. Then dividend 0, divisor 5, lz_count=32 -> ready in cycle 1, quotient=0, remainder=0.
- Unsigned 32'hFFFFFFFF / 1, lz_count=0 -> ready in cycle 33, quotient=32'hFFFFFFFF, remainder=0. Extra start at cycle 5 with other operands is ignored; the result is unchanged.
- Signed 32'h80000000 / 32'hFFFFFFFF, lz_count=0 -> ready in cycle 33, quotient=32'h80000000, remainder=0.
- Same divide as the previous case with cancel in cycle 3 -> busy=0 in cycle 4, no ready, outputs keep prior values. Separately, clrn low in cycle 10 of a run -> all outputs 0 next cycle, no ready.
